tx_burst_ctrl: RTL

- Transmit sequencer for the I2C-style serial TX path.
- Accepts a burst command: beat count plus beat size in bytes.
- Fetches each beat over a valid/ready data port and shifts it out MSB-first, one bit per bit_tick. Between beats it samples the receiver's ACK slot.
- Owns the beat and bit counters, and reports completion or errors (illegal config, NACK, abort) to the host-side command logic.

---
 rtl/tx_pkg.sv | 22 ++
 rtl/tx_shift_unit.sv | 49 ++++
 rtl/tx_burst_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the serial TX burst sequencer: state encoding, limits and
// the power-of-two legality helper.
package tx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t CHECK = 3'd1;
   localparam state_t FETCH = 3'd2;
   localparam state_t SHIFT = 3'd3;
   localparam state_t ACK   = 3'd4;
   localparam state_t FIN   = 3'd5;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned MAX_SIZE  = 4;
   localparam int unsigned MAX_BURST = 64;

   function automatic logic is_pow2_le(input int unsigned val, input int unsigned max_val);
      return (val != 0) && ((val & (val - 1)) == 0) && (val <= max_val);
   endfunction

endpackage

// File: rtl/tx_shift_unit.sv
// Beat shift register: loads a beat left-aligned, shifts it out MSB-first and
// tracks how many bits of the current beat remain.
module tx_shift_unit #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic              clr,
   input  logic              oe,
   input  logic [3:0]        size,
   input  logic [DATA_W-1:0] data_in,
   output logic              sda_out,
   output logic [5:0]        bits_left
);
   import tx_pkg::*;

   localparam int unsigned SW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sreg_q;
   logic [5:0]        bits_q;
   logic [6:0]        act_bits;
   logic [SW-1:0]     shamt;

   assign act_bits = {size, 3'b000};
   // Left-align the active bytes; anything above the active width falls off the top.
   assign shamt    = SW'(DATA_W) - SW'(act_bits);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         bits_q <= '0;
      end else if (clr) begin
         sreg_q <= '0;
         bits_q <= '0;
      end else if (load) begin
         sreg_q <= data_in << shamt;
         bits_q <= act_bits[5:0];
      end else if (shift) begin
         sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
         bits_q <= bits_q - 6'd1;
      end
   end

   assign sda_out   = oe & sreg_q[DATA_W-1];
   assign bits_left = bits_q;

endmodule

// File: rtl/tx_burst_ctrl.sv
// Burst transmit sequencer: validates a command, fetches each beat, serialises it
// on bit_tick and samples the ACK slot, reporting completion and errors.
module tx_burst_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_SIZE  = tx_pkg::MAX_SIZE,
   parameter int unsigned MAX_BURST = tx_pkg::MAX_BURST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [6:0]        cmd_burst,
   input  logic [3:0]        cmd_size,
   input  logic              abort,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic              bit_tick,
   input  logic              ack_in,
   output logic              sda_out,
   output logic              sda_oe,
   output logic              busy,
   output logic              done,
   output logic              err_cfg,
   output logic              err_nack,
   output logic              err_abort,
   output logic [6:0]        beats_left,
   output logic [5:0]        bits_left
);
   import tx_pkg::*;

   state_t     state_q, state_d;
   logic [6:0] burst_q, beats_q, beats_d;
   logic [3:0] size_q;
   logic       done_q, cfg_q, nack_q, abrt_q;
   logic       cfg_d, nack_d, abrt_d;
   logic       load, shift, cfg_ok, active;

   assign cfg_ok = is_pow2_le(32'(burst_q), MAX_BURST) && is_pow2_le(32'(size_q), MAX_SIZE);
   assign active = (state_q != IDLE) && (state_q != FIN);

   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      load    = 1'b0;
      shift   = 1'b0;
      cfg_d   = 1'b0;
      nack_d  = 1'b0;
      abrt_d  = 1'b0;
      // Abort wins over any tick or handshake landing in the same cycle.
      if (abort && active) begin
         state_d = FIN;
         abrt_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (cmd_valid) state_d = CHECK;
            CHECK: begin
               if (cfg_ok) begin
                  beats_d = burst_q;
                  state_d = FETCH;
               end else begin
                  state_d = FIN;
                  cfg_d   = 1'b1;
               end
            end
            FETCH: begin
               if (data_valid) begin
                  load    = 1'b1;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (bit_tick) begin
                  shift = 1'b1;
                  if (bits_left == 6'd1) state_d = ACK;
               end
            end
            ACK: begin
               if (bit_tick) begin
                  if (!ack_in) begin
                     beats_d = beats_q - 7'd1;
                     state_d = (beats_q == 7'd1) ? FIN : FETCH;
                  end else begin
                     state_d = FIN;
                     nack_d  = 1'b1;
                  end
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         burst_q <= '0;
         size_q  <= '0;
         beats_q <= '0;
         done_q  <= 1'b0;
         cfg_q   <= 1'b0;
         nack_q  <= 1'b0;
         abrt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         done_q  <= (state_d == FIN);
         cfg_q   <= cfg_d;
         nack_q  <= nack_d;
         abrt_q  <= abrt_d;
         if (state_q == IDLE && cmd_valid) begin
            burst_q <= cmd_burst;
            size_q  <= cmd_size;
         end
      end
   end

   tx_shift_unit #(
      .DATA_W (DATA_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .shift     (shift),
      .clr       (state_q == FIN),
      .oe        (sda_oe),
      .size      (size_q),
      .data_in   (data_in),
      .sda_out   (sda_out),
      .bits_left (bits_left)
   );

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign data_ready = (state_q == FETCH) && !abort;
   assign sda_oe     = (state_q == SHIFT);
   assign done       = done_q;
   assign err_cfg    = cfg_q;
   assign err_nack   = nack_q;
   assign err_abort  = abrt_q;
   assign beats_left = beats_q;

endmodule
